// File: rtl/uart_rx_deser_if.sv
// Byte handshake between uart_rx_deser (master) and its consumer (slave).
// The parity_odd/parity_err pair exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_deser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       parity_err;

  modport master (
    output rx_valid, rx_data, frame_err, overrun, rx_busy, parity_err,
    input  rx_ready, parity_odd
  );

  modport slave (
    input  rx_valid, rx_data, frame_err, overrun, rx_busy, parity_err,
    output rx_ready, parity_odd
  );
`else
  modport master (
    output rx_valid, rx_data, frame_err, overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_data, frame_err, overrun, rx_busy,
    output rx_ready
  );
`endif
endinterface

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: 2-flop sync, 16x oversampling, mid-bit sampling, one-byte holding register.
// Optional UART_RX_PARITY_EN adds a parity bit (parity_odd selects odd/even) before the stop bit.
module uart_rx_deser #(
  parameter int BAUD_DIV = 27,
  parameter int OVS      = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            uart_rx,
  uart_rx_deser_if.master bus
);

  localparam int              DIV_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [3:0]      MID_TICK  = 4'(OVS / 2 - 1);
  localparam logic [3:0]      LAST_TICK = 4'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PAR   = 3'd5,
`endif
    S_BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             busy_q;
  logic             valid_q;
  logic [7:0]       data_q;
  logic             ovr_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr_q, perr_d;
`endif

  assign rx_s   = sync_q[1];
  assign tick_s = (div_q == DIV_LAST);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  // Next-state logic: divider, tick/bit counters, shifter and frame result pulses.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    // The divider restarts from zero on every start edge so ticks stay phase-aligned to it.
    if ((state_q == S_IDLE) || (state_q == S_BRK) || tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tcnt_d  = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          if (tcnt_q == MID_TICK) begin
            tcnt_d  = 4'd0;
            bcnt_d  = 3'd0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PAR;
`else
              state_d = S_STOP;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            shift_d = shift_q;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST_TICK) begin
            par_bad_d = ((^shift_q) ^ rx_s) != bus.parity_odd;
            state_d   = S_STOP;
          end else begin
            state_d = S_PAR;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
`endif
      S_STOP: begin
        if (tick_s) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == LAST_TICK) begin
`ifdef UART_RX_PARITY_EN
            perr_d = par_bad_q;
            done_d = rx_s & ~par_bad_q;
`else
            done_d = rx_s;
`endif
            ferr_d  = ~rx_s;
            state_d = rx_s ? S_IDLE : S_BRK;
          end else begin
            state_d = S_STOP;
          end
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_BRK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BRK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Receiver state registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      tcnt_q  <= 4'd0;
      bcnt_q  <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Holding register: a new byte is dropped with an overrun pulse unless the slot is free or being popped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (valid_q && !bus.rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_valid  = valid_q;
  assign bus.rx_data   = data_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.rx_busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- UART receive deserializer for soc2: takes the asynchronous `uart_rx` pad line and produces 8N1 bytes (8 data bits, no parity, 1 stop bit) on a valid/ready interface.
- Sits directly upstream of the peripheral UART register/interrupt logic in `u_peri`. That logic consumes `rx_data`/`rx_valid` and reports the byte to the core.
- Uses 16x oversampling with mid-bit sampling, a one-byte holding register, and framing-error and overrun flags.

Parameters:
- BAUD_DIV, 27, clk cycles per oversample tick (1 = tick every clk). 50 MHz / (115200 × 16) ≈ 27.
- OVS, 16, oversample ticks per bit. Fixed at 16; must be even.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- uart_rx  in  1  asynchronous serial input, idle high
- rx_ready  in  1  consumer accepts the byte
- rx_valid  out  1  holding register holds an unread byte
- rx_data  out  8  received byte, LSB received first
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: a completed byte was dropped
- rx_busy  out  1  state machine is not in IDLE

Behaviour:
- Reset: one clock; reset is synchronous and active-low (`resetn` sampled on the `clk` rising edge).
  - While `resetn` = 0: `rx_valid` = 0, `rx_data` = 8'h00, `frame_err` = 0, `overrun` = 0, `rx_busy` = 0.
  - Synchronizer flops reset to 1; state = IDLE; all counters = 0.
  - Reset asserted mid-frame aborts the frame and drops the pending byte.
- Input synchronization:
  - 2-flop synchronizer on `uart_rx`, output `rx_s`.
  - All decisions use `rx_s`, which gives 2 clk of input latency.
- Tick generator:
  - Divider counts 0..BAUD_DIV-1; `tick` pulses when the count reaches BAUD_DIV-1.
  - Divider is held at 0 in IDLE, so the first tick after a start edge is a full BAUD_DIV later.
- State machine (`tcnt` = 4-bit tick counter, `bcnt` = 3-bit bit counter):
  - IDLE:
    - `rx_s` = 0 → START; clear `tcnt`.
  - START:
    - On each tick, `tcnt`++.
    - When the 8th tick arrives (mid start bit): if `rx_s` = 0 → DATA with `tcnt`=0, `bcnt`=0; else → IDLE (glitch rejected, no flag raised).
  - DATA:
    - On each tick, `tcnt`++.
    - On the 16th tick: shift `rx_s` into shift[7] (right shift); `bcnt`++.
    - After the 8th data bit → STOP (or PARITY when the optional feature is compiled in).
  - STOP:
    - On the 16th tick, sample `rx_s`.
    - If 1: deliver the byte (see Holding register) → IDLE.
    - If 0: pulse `frame_err`, discard the byte → BREAK.
  - BREAK:
    - Wait until `rx_s` = 1 → IDLE. A line held low is never re-framed.
- Holding register:
  - A delivered byte loads `rx_data`, and `rx_valid` = 1 on the next cycle.
  - `rx_valid && rx_ready` clears `rx_valid` at that edge.
  - Byte completes while `rx_valid` = 1 and `rx_ready` = 0: keep the old byte, drop the new one, pulse `overrun` for 1 cycle.
  - Byte completes in the same cycle as a pop: load the new byte, `rx_valid` stays 1, no overrun.
  - `rx_data` is stable while `rx_valid` = 1.
- Latency with BAUD_DIV = 1:
  - `rx_valid` rises exactly 155 clk after the first clock edge that samples `uart_rx` = 0.
  - Breakdown: 2 (sync) + 8 (start) + 128 (data) + 16 (stop) + 1 (register load).
- `rx_busy` = (state != IDLE).

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled on its 16th tick.
  - Adds input port `parity_odd` (1 bit; 0 = even, 1 = odd) and output `parity_err` (1-cycle pulse).
  - On parity mismatch: pulse `parity_err` at the stop sample, discard the byte, still go to IDLE (or to BREAK if the stop bit is also low).
  - With BAUD_DIV = 1, delivery latency becomes 171 clk.
- Undefined: no PARITY state, no `parity_odd`/`parity_err` ports; pure 8N1.

Test Plan:
- BAUD_DIV=1, send 0x5A 8N1, `rx_ready`=1 → `rx_valid` high for 1 cycle, exactly 155 clk after the start edge, `rx_data`=8'h5A; no `frame_err`/`overrun`.
- Line low for 5 clk, then high (glitch) → back to IDLE; `rx_valid`, `frame_err`, `overrun` all stay 0; `rx_busy` drops 11 clk after the falling edge.
- Send 0x07 with stop bit = 0, then hold line low 40 clk → `frame_err` pulses once; no `rx_valid`; `rx_busy` stays 1 until the line returns high.
- `rx_ready`=0, send 0x07 then 0x05 → `rx_valid`=1, `rx_data`=8'h07; `overrun` pulses at the second stop sample; after `rx_ready`=1, `rx_data` is still 0x07, then `rx_valid`=0.
- Assert `resetn`=0 for 1 clk mid-way through the data bits of 0xFF → all outputs zero; the next clean 0x3C is received correctly.
- UART_RX_PARITY_EN, `parity_odd`=0, send 0x5A with parity bit 1 → `parity_err` pulses, no `rx_valid`; with parity bit 0 → `rx_data`=0x5A at 171 clk.
